// File: rtl/dxp_assembly2ir_v.sv
// dxp_assembly2ir_v: ASCII assembly statement to 16-bit IW
// Inverse of the IW-to-ASCII debug display; ready/valid both sides
module dxp_assembly2ir_v #(
  parameter logic [1:0] IR_HI    = 2'b00,
  parameter int         MNEM_MAX = 4
) (
  input  logic        Clock_pin,
  input  logic        Reset_pin,
  input  logic [7:0]  ch_in,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [15:0] iw_out,
  output logic        iw_valid,
  input  logic        iw_ready,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] iw_count
);

  typedef enum logic [3:0] {
    S_MNEM, S_OPA, S_OPA_D, S_COMMA, S_OPB,
    S_OPB_M, S_OPB_D, S_TERM, S_EMIT, S_SKIP
  } state_t;

  typedef enum logic [2:0] {
    C_RR, C_RI, C_R, C_MEM, C_JMP, C_BAD
  } cls_t;

  localparam logic [2:0] E_MNEM  = 3'd1;
  localparam logic [2:0] E_PFX   = 3'd2;
  localparam logic [2:0] E_DIG   = 3'd3;
  localparam logic [2:0] E_COMMA = 3'd4;
  localparam logic [2:0] E_TERM  = 3'd5;
  localparam logic [2:0] CMAX    = 3'(MNEM_MAX);

  state_t      r_state, w_next;
  logic [31:0] r_mn;
  logic [2:0]  r_cnt;
  logic [5:0]  r_op, w_op_n;
  cls_t        r_cls, w_cls_n;
  logic [3:0]  r_a, r_b, r_jl;
  logic [3:0]  w_a_n, w_b_n, w_jl_n;
  logic [15:0] r_iw, r_cnt_iw;
  logic        r_err;
  logic [2:0]  r_code;

  logic [7:0]  w_c;
  logic        w_acc, w_ws, w_let, w_hex, w_sc;
  logic [3:0]  w_hv;
  logic [5:0]  w_lk_op;
  cls_t        w_lk_cls;
  logic        w_err, w_ld_iw, w_inc;
  logic [2:0]  w_code;

  assign ch_ready = (r_state != S_EMIT);
  assign iw_valid = (r_state == S_EMIT);
  assign w_acc    = ch_valid && (r_state != S_EMIT);
  assign iw_out   = r_iw;
  assign iw_count = r_cnt_iw;
  assign err      = r_err;
  assign err_code = r_code;

  // fold case and classify the incoming character
  always_comb begin
    w_c = ch_in;
    if (ch_in >= "a" && ch_in <= "z")
      w_c = ch_in - 8'h20;
    w_ws  = (w_c == 8'h20) || (w_c == 8'h09) ||
            (w_c == 8'h0A) || (w_c == 8'h0D);
    w_let = (w_c >= "A") && (w_c <= "Z");
    w_sc  = (w_c == ";");
    w_hex = 1'b0;
    w_hv  = 4'd0;
    if (w_c >= "0" && w_c <= "9") begin
      w_hex = 1'b1;
      w_hv  = w_c[3:0];
    end else if (w_c >= "A" && w_c <= "F") begin
      w_hex = 1'b1;
      w_hv  = w_c[3:0] + 4'd9;
    end
  end

  // mnemonic lookup on the collected letters
  always_comb begin
    w_lk_op  = 6'h00;
    w_lk_cls = C_BAD;
    case (r_mn)
      {16'd0, "LD"}:   begin w_lk_op = 6'h00; w_lk_cls = C_MEM; end
      {16'd0, "ST"}:   begin w_lk_op = 6'h01; w_lk_cls = C_MEM; end
      {8'd0,  "CPY"}:  begin w_lk_op = 6'h02; w_lk_cls = C_RR;  end
      "SWAP":          begin w_lk_op = 6'h03; w_lk_cls = C_RR;  end
      "JUMP":          begin w_lk_op = 6'h04; w_lk_cls = C_JMP; end
      {8'd0,  "ADD"}:  begin w_lk_op = 6'h05; w_lk_cls = C_RR;  end
      {8'd0,  "SUB"}:  begin w_lk_op = 6'h06; w_lk_cls = C_RR;  end
      "ADDC":          begin w_lk_op = 6'h07; w_lk_cls = C_RI;  end
      "SUBC":          begin w_lk_op = 6'h08; w_lk_cls = C_RI;  end
      {8'd0,  "MUL"}:  begin w_lk_op = 6'h09; w_lk_cls = C_RR;  end
      {8'd0,  "DIV"}:  begin w_lk_op = 6'h0A; w_lk_cls = C_RR;  end
      {8'd0,  "NOT"}:  begin w_lk_op = 6'h0B; w_lk_cls = C_R;   end
      {8'd0,  "AND"}:  begin w_lk_op = 6'h0C; w_lk_cls = C_RR;  end
      {16'd0, "OR"}:   begin w_lk_op = 6'h0D; w_lk_cls = C_RR;  end
      {8'd0,  "XOR"}:  begin w_lk_op = 6'h0E; w_lk_cls = C_RR;  end
      {8'd0,  "SRL"}:  begin w_lk_op = 6'h0F; w_lk_cls = C_RI;  end
      {8'd0,  "SRA"}:  begin w_lk_op = 6'h10; w_lk_cls = C_RI;  end
      "ROTL":          begin w_lk_op = 6'h11; w_lk_cls = C_RI;  end
      "ROTR":          begin w_lk_op = 6'h12; w_lk_cls = C_RI;  end
      {8'd0,  "RLN"}:  begin w_lk_op = 6'h13; w_lk_cls = C_RI;  end
      {8'd0,  "RLZ"}:  begin w_lk_op = 6'h14; w_lk_cls = C_RI;  end
      {8'd0,  "RRC"}:  begin w_lk_op = 6'h15; w_lk_cls = C_RI;  end
      {8'd0,  "RRV"}:  begin w_lk_op = 6'h16; w_lk_cls = C_RI;  end
      "VADD":          begin w_lk_op = 6'h17; w_lk_cls = C_RR;  end
      "VSUB":          begin w_lk_op = 6'h18; w_lk_cls = C_RR;  end
      default:         begin w_lk_op = 6'h00; w_lk_cls = C_BAD; end
    endcase
  end

  // parser next-state, field updates and error detection
  always_comb begin
    w_next  = r_state;
    w_err   = 1'b0;
    w_code  = 3'd0;
    w_op_n  = r_op;
    w_cls_n = r_cls;
    w_a_n   = r_a;
    w_b_n   = r_b;
    w_jl_n  = r_jl;
    w_ld_iw = 1'b0;
    w_inc   = 1'b0;
    if (r_state == S_EMIT) begin
      if (iw_ready) begin
        w_inc  = 1'b1;
        w_next = S_MNEM;
      end
    end else if (w_acc) begin
      unique case (r_state)
        S_MNEM: begin
          if (w_let) begin
            if (r_cnt >= CMAX) begin
              w_err = 1'b1; w_code = E_MNEM;
            end
          end else if (w_ws) begin
            if (r_cnt != 3'd0) begin
              if (w_lk_cls == C_BAD) begin
                w_err = 1'b1; w_code = E_MNEM;
              end else begin
                w_op_n  = w_lk_op;
                w_cls_n = w_lk_cls;
                w_a_n   = 4'd0;
                w_b_n   = 4'd0;
                w_next  = S_OPA;
              end
            end
          end else if (w_sc) begin
            if (r_cnt != 3'd0) begin
              w_err = 1'b1; w_code = E_MNEM;
            end
          end else begin
            w_err = 1'b1; w_code = E_MNEM;
          end
        end
        S_OPA: begin
          if (w_ws) begin
            w_next = S_OPA;
          end else if (r_cls == C_JMP) begin
            case (w_c)
              "U": begin w_b_n = 4'd0; w_next = S_TERM; end
              "C": begin w_jl_n = 4'b1000; w_next = S_OPA_D; end
              "N": begin w_jl_n = 4'b0100; w_next = S_OPA_D; end
              "V": begin w_jl_n = 4'b0010; w_next = S_OPA_D; end
              "Z": begin w_jl_n = 4'b0001; w_next = S_OPA_D; end
              default: begin w_err = 1'b1; w_code = E_PFX; end
            endcase
          end else if (w_c == "R") begin
            w_next = S_OPA_D;
          end else begin
            w_err = 1'b1; w_code = E_PFX;
          end
        end
        S_OPA_D: begin
          if (r_cls == C_JMP) begin
            if (w_c == "1") begin
              w_b_n = r_jl; w_next = S_TERM;
            end else if (w_c == "0") begin
              w_b_n = ~r_jl; w_next = S_TERM;
            end else begin
              w_err = 1'b1; w_code = E_DIG;
            end
          end else if (w_hex) begin
            if (r_cls == C_MEM) w_b_n = w_hv;
            else                w_a_n = w_hv;
            w_next = (r_cls == C_R) ? S_TERM : S_COMMA;
          end else begin
            w_err = 1'b1; w_code = E_DIG;
          end
        end
        S_COMMA: begin
          if (w_ws) begin
            w_next = S_COMMA;
          end else if (w_c == ",") begin
            w_next = S_OPB;
          end else if (w_hex) begin
            w_err = 1'b1; w_code = E_DIG;
          end else begin
            w_err = 1'b1; w_code = E_COMMA;
          end
        end
        S_OPB: begin
          if (w_ws) begin
            w_next = S_OPB;
          end else if (r_cls == C_RR && w_c == "R") begin
            w_next = S_OPB_D;
          end else if (r_cls == C_RI && w_c == "#") begin
            w_next = S_OPB_D;
          end else if (r_cls == C_MEM && w_c == "M") begin
            w_next = S_OPB_M;
          end else begin
            w_err = 1'b1; w_code = E_PFX;
          end
        end
        S_OPB_M: begin
          if (w_c == "A") begin
            w_next = S_OPB_D;
          end else begin
            w_err = 1'b1; w_code = E_PFX;
          end
        end
        S_OPB_D: begin
          if (w_hex) begin
            if (r_cls == C_MEM) w_a_n = w_hv;
            else                w_b_n = w_hv;
            w_next = S_TERM;
          end else begin
            w_err = 1'b1; w_code = E_DIG;
          end
        end
        S_TERM: begin
          if (w_ws) begin
            w_next = S_TERM;
          end else if (w_sc) begin
            w_ld_iw = 1'b1;
            w_next  = S_EMIT;
          end else if (w_hex) begin
            w_err = 1'b1; w_code = E_DIG;
          end else begin
            w_err = 1'b1; w_code = E_TERM;
          end
        end
        S_SKIP: begin
          if (w_sc) w_next = S_MNEM;
        end
        default: w_next = S_MNEM;
      endcase
      if (w_err) w_next = w_sc ? S_MNEM : S_SKIP;
    end
  end

  // state register
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) r_state <= S_MNEM;
    else           r_state <= w_next;
  end

  // mnemonic shift register, emptied whenever MNEM is left
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      r_mn  <= 32'd0;
      r_cnt <= 3'd0;
    end else if (w_acc && r_state == S_MNEM) begin
      if (w_let && r_cnt < CMAX) begin
        r_mn  <= {r_mn[23:0], w_c};
        r_cnt <= r_cnt + 3'd1;
      end else begin
        r_mn  <= 32'd0;
        r_cnt <= 3'd0;
      end
    end
  end

  // operand fields, output word, accepted-IW count, error pulse
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      r_op     <= 6'd0;
      r_cls    <= C_RR;
      r_a      <= 4'd0;
      r_b      <= 4'd0;
      r_jl     <= 4'd0;
      r_iw     <= 16'd0;
      r_cnt_iw <= 16'd0;
      r_err    <= 1'b0;
      r_code   <= 3'd0;
    end else begin
      r_op   <= w_op_n;
      r_cls  <= w_cls_n;
      r_a    <= w_a_n;
      r_b    <= w_b_n;
      r_jl   <= w_jl_n;
      r_err  <= w_err;
      r_code <= w_err ? w_code : 3'd0;
      if (w_ld_iw) r_iw <= {IR_HI, r_op, r_a, r_b};
      if (w_inc)   r_cnt_iw <= r_cnt_iw + 16'd1;
    end
  end

endmodule

// File: tb/tb_dxp_assembly2ir_v.sv
// tb_dxp_assembly2ir_v: scoreboard bench for the assembler
// Expected IWs / error codes queued at drive time, popped on output
module tb_dxp_assembly2ir_v;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ch_in = 8'd0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [15:0] iw_out;
  logic        iw_valid;
  logic        iw_ready = 1'b1;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] iw_count;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] q_iw[$];
  logic [2:0]  q_er[$];
  int          m_cnt = 0;
  bit          prev_hs = 0;
  bit          prev_err = 0;
  bit          rnd_done = 0;

  dxp_assembly2ir_v dut (
    .Clock_pin (clk),
    .Reset_pin (rst),
    .ch_in     (ch_in),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .iw_out    (iw_out),
    .iw_valid  (iw_valid),
    .iw_ready  (iw_ready),
    .err       (err),
    .err_code  (err_code),
    .iw_count  (iw_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic hs;
    if (rst) begin
      m_cnt    = 0;
      prev_hs  = 0;
      prev_err = 0;
    end else begin
      if (prev_hs) begin
        check("vld_drop", iw_valid, 0);
        check("rdy_back", ch_ready, 1);
      end
      if (err) begin
        check("err_1cyc", prev_err, 0);
        if (q_er.size() == 0) check("err_q", q_er.size(), 1);
        else check("err_code", err_code, q_er.pop_front());
      end
      prev_err = err;
      hs = iw_valid && iw_ready;
      if (hs) begin
        check("count", iw_count, m_cnt);
        if (q_iw.size() == 0) check("iw_q", q_iw.size(), 1);
        else check("iw", iw_out, q_iw.pop_front());
        m_cnt = (m_cnt + 1) & 16'hFFFF;
      end
      prev_hs = hs;
    end
  end

  task automatic send_ch(input logic [7:0] c);
    int n;
    n = 0;
    ch_in = c;
    ch_valid = 1'b1;
    while (!ch_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("ch_rdy_to", ch_ready, 1);
    @(posedge clk); #1;
    ch_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_ch(s[i]);
  endtask

  task automatic stmt_ok(input string s, input logic [15:0] iw);
    q_iw.push_back(iw);
    send_str(s);
    check("lat", iw_valid, 1);
  endtask

  task automatic stmt_err(input string s, input logic [2:0] code);
    q_er.push_back(code);
    send_str(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    string nm[4];
    logic [5:0] op[4];
    nm = '{"ADD", "SUB", "AND", "XOR"};
    op = '{6'h05, 6'h06, 6'h0C, 6'h0E};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ch_ready", ch_ready, 1);
    check("rst_iw_out", iw_out, 0);
    check("rst_iw_valid", iw_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_iw_count", iw_count, 0);

    stmt_ok("ADD R3, R5;", 16'h0535);
    stmt_ok("srl r2,#4;", 16'h0F24);
    stmt_ok("JUMP Z0;", 16'h040E);
    stmt_ok("LD R1, MA7;", 16'h0071);
    stmt_ok("NOT RA;", 16'h0BA0);
    stmt_err("FOO R1;", 3'd1);
    stmt_ok(" ADD R1,R2;", 16'h0512);
    stmt_err("SUB R1 R2;", 3'd4);
    stmt_err("ADD R12,R1;", 3'd3);
    stmt_ok("JUMP U;", 16'h0400);
    stmt_ok("jump c1;", 16'h0408);
    stmt_ok("\naddc\tr5,#F;", 16'h075F);
    stmt_ok("VSUB RE,R9;", 16'h18E9);
    stmt_ok("ST R2 , MA3;", 16'h0132);
    stmt_err("ROTLX R1;", 3'd1);
    stmt_err("ADD R1,X2;", 3'd2);
    stmt_err("ADD R1,R2 Q;", 3'd5);
    stmt_err("ADD R1;", 3'd4);
    stmt_ok("OR R1,R2;", 16'h0D12);
    send_str(";");
    stmt_ok(" XOR R3,R4;", 16'h0E34);

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int k;
          logic [3:0] a, b;
          k = $urandom_range(0, 3);
          a = 4'($urandom_range(0, 15));
          b = 4'($urandom_range(0, 15));
          stmt_ok($sformatf("%s r%h ,R%h;", nm[k], a, b),
                  {2'b00, op[k], a, b});
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          iw_ready = 1'($urandom_range(0, 1));
        end
        iw_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    iw_ready = 1'b0;
    send_str("CPY R0,RF;");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", iw_valid, 1);
      check("hold_iw", iw_out, 16'h020F);
      check("hold_ready", ch_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", iw_valid, 0);
    check("mid_rst_count", iw_count, 0);
    check("mid_rst_ready", ch_ready, 1);
    check("mid_rst_iw", iw_out, 0);
    iw_ready = 1'b1;
    stmt_ok("ADD R3,R5;", 16'h0535);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("iw_q_empty", q_iw.size(), 0);
    check("err_q_empty", q_er.size(), 0);
    check("final_count", iw_count, m_cnt);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
